// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the UART receive and transmit blocks.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 16;
   localparam int UART_DATA_BITS    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous RX line plus a falling-edge detector.
module uart_rx_sync_edge (
   input  logic det_clk,
   input  logic det_rst_n,
   input  logic line_in,
   output logic line_sync,
   output logic line_fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   // All flops reset high so a released reset never looks like a start edge.
   always_ff @(posedge det_clk or negedge det_rst_n) begin
      if (!det_rst_n) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= line_in;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign line_sync = sync_reg;
   assign line_fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, mid-bit sampling, LSB-first assembly,
// stop-bit check and a one-entry valid/ready output buffer with error flags.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 rx_ovr_clr,
   output logic                 rx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic line_sync;
   logic line_fall;

   uart_rx_sync_edge u_sync_edge (
      .det_clk   (rx_clk),
      .det_rst_n (rx_rst_n),
      .line_in   (rx_in),
      .line_sync (line_sync),
      .line_fall (line_fall)
   );

   uart_rx_state_e       state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 stop_done_reg;

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         shift_reg     <= '0;
         stop_done_reg <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
         rx_busy       <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (rx_ovr_clr)
            rx_overrun <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (line_fall) begin
                  state_reg <= START;
                  cnt_reg   <= '0;
                  rx_busy   <= 1'b1;
               end
            end

            START: begin
               if (cnt_reg == HALF_CNT) begin
                  cnt_reg <= '0;
                  if (!line_sync) begin
                     state_reg <= DATA;
                     idx_reg   <= '0;
                  end else begin
                     state_reg <= IDLE;
                     rx_busy   <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt_reg == FULL_CNT) begin
                  cnt_reg   <= '0;
                  shift_reg <= {line_sync, shift_reg[DATA_BITS-1:1]};
                  if (idx_reg == LAST_IDX)
                     state_reg <= STOP;
                  else
                     idx_reg <= idx_reg + IDX_W'(1);
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            STOP: begin
               // One extra cycle after the stop sample before start edges are watched again.
               if (stop_done_reg) begin
                  stop_done_reg <= 1'b0;
                  state_reg     <= IDLE;
                  cnt_reg       <= '0;
                  rx_busy       <= 1'b0;
               end else if (cnt_reg == FULL_CNT) begin
                  stop_done_reg <= 1'b1;
                  if (line_sync) begin
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        rx_overrun <= 1'b1;
                     end
                  end else begin
                     rx_frame_err <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
